// File: rtl/cypher_detector_if.sv
// Digit-entry bus between a keypad front end (master) and cypher_detector (slave).
interface cypher_detector_if #(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 4,
  parameter int SUM_W   = 8
);
  logic [DIGITS*DIGIT_W-1:0] cypher;
  logic [DIGIT_W-1:0]        num;
  logic                      read;
  logic [SUM_W-1:0]          sum;
  logic                      right;

  modport master (output cypher, output num, output read, input sum, input right);
  modport slave  (input cypher, input num, input read, output sum, output right);
endinterface

// File: rtl/cypher_detector.sv
// Serial combination-lock detector: matches the last DIGITS accepted digits against a captured code.
// Optional CYPHER_DETECTOR_REARM_EN: right pulses once per match and the detector re-arms with the same code.
module cypher_detector #(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 4,
  parameter int SUM_W   = 8
) (
  input logic              clock,
  input logic              reset,
  cypher_detector_if.slave bus
);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, FILL, SCAN, FOUND} state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   win_q, win_d, win_shift;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d, sum_base;
  logic                right_q, right_d;
`ifdef CYPHER_DETECTOR_REARM_EN
  logic                clr_q, clr_d;
`endif

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [DIGIT_W-1:0] b);
    logic [SUM_W:0] t;
    t = {1'b0, a} + {{(SUM_W + 1 - DIGIT_W){1'b0}}, b};
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

  // Newest digit enters at the top, so after DIGITS shifts the oldest sits in bits [DIGIT_W-1:0].
  assign win_shift = {bus.num, win_q[CODE_W-1:DIGIT_W]};

`ifdef CYPHER_DETECTOR_REARM_EN
  assign sum_base = clr_q ? '0 : sum_q;
`else
  assign sum_base = sum_q;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
`ifdef CYPHER_DETECTOR_REARM_EN
    right_d = 1'b0;
    clr_d   = clr_q;
`else
    right_d = right_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.read) begin
          code_d  = bus.cypher;
          win_d   = win_shift;
          sum_d   = sat_add(sum_base, bus.num);
          cnt_d   = CNT_W'(1);
          state_d = FILL;
`ifdef CYPHER_DETECTOR_REARM_EN
          clr_d   = 1'b0;
`endif
        end
      end
      FILL, SCAN: begin
        if (bus.read) begin
          win_d = win_shift;
          sum_d = sat_add(sum_base, bus.num);
          cnt_d = (cnt_q == CNT_W'(DIGITS)) ? cnt_q : cnt_q + 1'b1;
`ifdef CYPHER_DETECTOR_REARM_EN
          clr_d = 1'b0;
`endif
          if (cnt_d == CNT_W'(DIGITS)) begin
            state_d = SCAN;
            if (win_shift == code_q) begin
              right_d = 1'b1;
`ifdef CYPHER_DETECTOR_REARM_EN
              state_d = FILL;
              win_d   = '0;
              cnt_d   = '0;
              clr_d   = 1'b1;
`else
              state_d = FOUND;
`endif
            end
          end
        end
      end
      FOUND: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      right_q <= 1'b0;
`ifdef CYPHER_DETECTOR_REARM_EN
      clr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      right_q <= right_d;
`ifdef CYPHER_DETECTOR_REARM_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // The code register only loads at the IDLE capture edge, so it needs no reset.
  always_ff @(posedge clock) begin
    code_q <= code_d;
  end

  assign bus.sum   = sum_q;
  assign bus.right = right_q;
endmodule

// File: tb/tb_cypher_detector.sv
// Self-checking bench for cypher_detector: directed scenarios plus randomized streams vs. a digit-history model.
module tb_cypher_detector;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cypher_detector_if bus ();
  cypher_detector dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: list of accepted digits, plain saturating integer sum.
  int          hist[$];
  int          exp_sum;
  bit          exp_right;
  bit          idle, found, started, pend_clr;
  logic [15:0] code;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      hist.delete();
      exp_sum = 0; exp_right = 0; idle = 1; found = 0; pend_clr = 0; started = 1;
    end else if (started) begin
`ifdef CYPHER_DETECTOR_REARM_EN
      exp_right = 0;
`endif
      if (bus.read && !found) begin
        bit m;
        if (idle) begin code = bus.cypher; idle = 0; end
        if (pend_clr) begin exp_sum = 0; pend_clr = 0; end
        hist.push_back(int'(bus.num));
        if (hist.size() > 4) void'(hist.pop_front());
        exp_sum = exp_sum + int'(bus.num);
        if (exp_sum > 255) exp_sum = 255;
        m = (hist.size() == 4);
        for (int k = 0; k < 4 && m; k++)
          if (hist.size() == 4 && hist[k] != int'((code >> (4 * k)) & 16'hF)) m = 0;
        if (m) begin
          exp_right = 1;
`ifdef CYPHER_DETECTOR_REARM_EN
          hist.delete();
          pend_clr = 1;
`else
          found = 1;
`endif
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      check("sum", int'(bus.sum), exp_sum);
      check("right", int'(bus.right), int'(exp_right));
    end
  end

  task automatic step(input bit r, input bit rd, input logic [3:0] n);
    @(negedge clock);
    reset = r; bus.read = rd; bus.num = n;
    @(posedge clock);
    #1;
  endtask

  task automatic stream(input logic [15:0] c, input int len, input int d[16]);
    bus.cypher = c;
    for (int i = 0; i < len; i++) step(0, 1, 4'(d[i]));
  endtask

  task automatic lit(input string name, input int s, input bit r);
    check({name, "_sum"}, int'(bus.sum), s);
    check({name, "_right"}, int'(bus.right), int'(r));
  endtask

  initial begin
    int d[16];
    bus.cypher = 16'h0; bus.num = 4'h0; bus.read = 1'b0;
    step(1, 0, 0); step(1, 0, 0);
    lit("reset", 0, 0);

    // 0x5574 : match on the 11th digit.
    step(0, 0, 0);
    d = '{4, 1, 5, 5, 2, 0, 2, 4, 7, 5, 0, 0, 0, 0, 0, 0};
    stream(16'h5574, 10, d);
    lit("t1_pre", 35, 0);
    step(0, 1, 5);
    lit("t1_match", 40, 1);
    d = '{6, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    stream(16'h5574, 3, d);
    lit("t1_frozen", 40, 1);
    step(0, 0, 0); step(0, 1, 9);
    lit("t1_found_hold", 40, 1);

    // Reset out of FOUND.
    step(1, 0, 0);
    lit("rst_found", 0, 0);

    // 0x2063 with cypher changing after capture.
    d = '{4, 1, 5, 5, 3, 6, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    bus.cypher = 16'h2063;
    step(0, 1, 4);
    bus.cypher = 16'hFFFF;
    for (int i = 1; i < 7; i++) step(0, 1, 4'(d[i]));
    lit("t2_pre", 24, 0);
    step(0, 1, 2);
    lit("t2_match", 26, 1);

    // 0x1111 with read gaps.
    step(1, 0, 0);
    bus.cypher = 16'h1111;
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 4'(i + 1));
    lit("t3_gap", 3, 0);
    step(0, 1, 1);
    lit("t3_match", 4, 1);

    // Overlap 0x3121.
    step(1, 0, 0);
    d = '{1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    stream(16'h3121, 5, d);
    lit("t4_pre", 7, 0);
    step(0, 1, 3);
    lit("t4_match", 10, 1);

    // Saturation with 0x0000.
    step(1, 0, 0);
    bus.cypher = 16'h0000;
    for (int i = 0; i < 20; i++) step(0, 1, 4'hF);
    lit("t5_sat", 255, 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    lit("t5_pre", 255, 0);
    step(0, 1, 0);
    lit("t5_match", 255, 1);

    // Randomized streams with small digit alphabet so matches occur.
    for (int r = 0; r < 12; r++) begin
      step(1, 0, 0);
      bus.cypher = 16'($urandom_range(0, 65535)) & 16'h3333;
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 15) == 0) bus.cypher = 16'($urandom);
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
             (r[0] ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 3))));
      end
    end

    step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
